mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences and shares the single-port MU0 memory between two requesters: the CPU core and the debug/loader port that preloads programs and inspects memory.
- Sits between both requesters and the memory block, and is the only driver of the memory's memRq, readNotWrite, addr and write-data inputs.
- Converts level-style memory strobes into a registered req/ack handshake with round-robin arbitration and a configurable access length.

Parameters:
ADDR_W, 16, requester and memory address width
DATA_W, 16, data width
WAIT_CYCLES, 1, cycles memRq is held per access (must be >= 1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
cpuReq  input  1  CPU access request (level)
cpuReadNotWrite  input  1  1 = read, 0 = write
cpuAddr  input  ADDR_W  CPU address
cpuDataIn  input  DATA_W  CPU write data
cpuAck  output  1  one-cycle completion pulse to CPU
cpuDataOut  output  DATA_W  CPU read data
dbgReq  input  1  debug access request (level)
dbgReadNotWrite  input  1  1 = read, 0 = write
dbgAddr  input  ADDR_W  debug address
dbgDataIn  input  DATA_W  debug write data
dbgAck  output  1  one-cycle completion pulse to debug port
dbgDataOut  output  DATA_W  debug read data
memRq  output  1  memory request strobe
readNotWrite  output  1  memory direction
addr  output  ADDR_W  memory address
memDataWr  output  DATA_W  to memory dataIn
memDataRd  input  DATA_W  from memory dataOut
busy  output  1  high whenever the FSM is not in IDLE
grantDbg  output  1  owner of the current or last transaction (1 = debug)

Behaviour:
- The block has one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - FSM in IDLE; memRq=0, readNotWrite=1, addr=0, memDataWr=0.
  - cpuAck=dbgAck=0, cpuDataOut=dbgDataOut=0, busy=0.
  - grantDbg=1, so the first tie goes to the CPU.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester not named by grantDbg (round-robin).
  - On a grant, latch the winner's readNotWrite, addr and data onto the memory outputs, load the wait counter with WAIT_CYCLES-1, update grantDbg, and go to ACCESS.
- ACCESS:
  - memRq=1. addr, readNotWrite and memDataWr stay stable for the whole state.
  - The counter decrements each cycle.
  - In the cycle the counter reads 0: if the access is a read, capture memDataRd into the granted requester's DataOut register; then go to DONE.
  - memRq is high for exactly WAIT_CYCLES consecutive cycles per access.
- DONE:
  - memRq=0 and readNotWrite=1, so the memory cannot accidentally write.
  - The granted requester's Ack=1 for this single cycle; DataOut is valid in this cycle.
  - Next state is IDLE.
- DataOut holds its value until that requester's next read completes. Writes never change DataOut.
- Latency: request seen in IDLE at cycle 0 -> memRq cycles 1..WAIT_CYCLES -> Ack at cycle WAIT_CYCLES+1. Back-to-back transactions occupy WAIT_CYCLES+2 cycles each.
- Handshake rules:
  - A requester holds Req and its operands stable until it samples Ack=1.
  - It deasserts Req on that same edge, so IDLE does not see a stale request.
  - Req dropping mid-transaction is ignored: the access completes and Ack still pulses.
  - Operand changes after the grant are ignored.
- Outside ACCESS, addr and memDataWr hold their last latched values; readNotWrite=1.
- The full ADDR_W address is passed through unmodified; memory-side decode and wrap-around are not this block's concern.
- Reset mid-ACCESS or mid-DONE:
  - The transaction is abandoned.
  - memRq=0 and no Ack from the next cycle.
  - DataOut registers clear to 0.
- Simultaneous requests always alternate: with both requesters continuously requesting, grants go CPU, DBG, CPU, ...

Test Plan:
- Preload mem[5]=0x1234; CPU read addr 5 -> memRq high exactly cycle 1; cpuAck at cycle 2 with cpuDataOut=0x1234; dbgAck stays 0.
- Debug write addr 3 data 0xBEEF, then CPU read addr 3 -> cpuDataOut=0xBEEF. Issue a CPU write afterwards -> cpuDataOut unchanged.
- Both Req high on the first cycle after reset -> CPU granted first, debug second. Repeat with both high -> debug granted, then CPU. grantDbg tracks each grant.
- Raise rst during ACCESS of a CPU write -> memRq=0 next cycle, no cpuAck, all outputs at reset values. A subsequent debug read completes normally.
- WAIT_CYCLES=3, CPU read addr 7 -> memRq high cycles 1-3 with addr=7 stable; cpuAck at cycle 4.
- CPU drops cpuReq during ACCESS -> cpuAck still pulses once; the FSM returns to IDLE; busy=0 afterwards.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares the single-port MU0 memory between the CPU and the debug/loader port.
// Round-robin arbitration, registered req/ack handshake, WAIT_CYCLES-long memRq strobe.
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpuReq,
  input  logic              cpuReadNotWrite,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuDataIn,
  output logic              cpuAck,
  output logic [DATA_W-1:0] cpuDataOut,
  input  logic              dbgReq,
  input  logic              dbgReadNotWrite,
  input  logic [ADDR_W-1:0] dbgAddr,
  input  logic [DATA_W-1:0] dbgDataIn,
  output logic              dbgAck,
  output logic [DATA_W-1:0] dbgDataOut,
  output logic              memRq,
  output logic              readNotWrite,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] memDataWr,
  input  logic [DATA_W-1:0] memDataRd,
  output logic              busy,
  output logic              grantDbg
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             any_req_c;
  logic             pick_dbg_c;

  // Winner selection: a tie goes to whoever did not own the last transaction
  always_comb begin
    any_req_c  = cpuReq | dbgReq;
    pick_dbg_c = dbgReq & (~cpuReq | ~grantDbg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      memRq        <= 1'b0;
      readNotWrite <= 1'b1;
      addr         <= '0;
      memDataWr    <= '0;
      cpuAck       <= 1'b0;
      dbgAck       <= 1'b0;
      cpuDataOut   <= '0;
      dbgDataOut   <= '0;
      busy         <= 1'b0;
      grantDbg     <= 1'b1;
    end else begin
      cpuAck <= 1'b0;
      dbgAck <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req_c) begin
            grantDbg     <= pick_dbg_c;
            readNotWrite <= pick_dbg_c ? dbgReadNotWrite : cpuReadNotWrite;
            addr         <= pick_dbg_c ? dbgAddr : cpuAddr;
            memDataWr    <= pick_dbg_c ? dbgDataIn : cpuDataIn;
            cnt          <= CNT_W'(WAIT_CYCLES - 1);
            memRq        <= 1'b1;
            busy         <= 1'b1;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (readNotWrite) begin
              if (grantDbg) dbgDataOut <= memDataRd;
              else          cpuDataOut <= memDataRd;
            end
            memRq        <= 1'b0;
            readNotWrite <= 1'b1;
            cpuAck       <= ~grantDbg;
            dbgAck       <= grantDbg;
            state        <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          memRq        <= 1'b0;
          readNotWrite <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two instances (WAIT_CYCLES 1 and 3), each with a small memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  // WAIT_CYCLES = 1 instance
  logic        cpu_req, cpu_rnw, cpu_ack, dbg_req, dbg_rnw, dbg_ack;
  logic [15:0] cpu_addr, cpu_din, cpu_dout, dbg_addr, dbg_din, dbg_dout;
  logic        mem_rq, rnw, busy, grant_dbg;
  logic [15:0] addr, mem_wr, mem_rd;
  logic [15:0] mem [0:15];

  // WAIT_CYCLES = 3 instance
  logic        c3_req, c3_rnw, c3_ack, d3_req, d3_rnw, d3_ack;
  logic [15:0] c3_addr, c3_din, c3_dout, d3_addr, d3_din, d3_dout;
  logic        mem_rq3, rnw3, busy3, grant_dbg3;
  logic [15:0] addr3, mem_wr3, mem_rd3;
  logic [15:0] mem3 [0:15];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .cpuReq(cpu_req), .cpuReadNotWrite(cpu_rnw), .cpuAddr(cpu_addr), .cpuDataIn(cpu_din),
    .cpuAck(cpu_ack), .cpuDataOut(cpu_dout),
    .dbgReq(dbg_req), .dbgReadNotWrite(dbg_rnw), .dbgAddr(dbg_addr), .dbgDataIn(dbg_din),
    .dbgAck(dbg_ack), .dbgDataOut(dbg_dout),
    .memRq(mem_rq), .readNotWrite(rnw), .addr(addr), .memDataWr(mem_wr), .memDataRd(mem_rd),
    .busy(busy), .grantDbg(grant_dbg)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .cpuReq(c3_req), .cpuReadNotWrite(c3_rnw), .cpuAddr(c3_addr), .cpuDataIn(c3_din),
    .cpuAck(c3_ack), .cpuDataOut(c3_dout),
    .dbgReq(d3_req), .dbgReadNotWrite(d3_rnw), .dbgAddr(d3_addr), .dbgDataIn(d3_din),
    .dbgAck(d3_ack), .dbgDataOut(d3_dout),
    .memRq(mem_rq3), .readNotWrite(rnw3), .addr(addr3), .memDataWr(mem_wr3), .memDataRd(mem_rd3),
    .busy(busy3), .grantDbg(grant_dbg3)
  );

  // Memory models: combinational read, write on the edge that ends a write strobe cycle
  assign mem_rd  = mem[addr[3:0]];
  assign mem_rd3 = mem3[addr3[3:0]];

  always @(posedge clk) begin
    if (mem_rq && !rnw) mem[addr[3:0]] <= mem_wr;
    if (mem_rq3 && !rnw3) mem3[addr3[3:0]] <= mem_wr3;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 0; cpu_rnw = 1; cpu_addr = '0; cpu_din = '0;
    dbg_req = 0; dbg_rnw = 1; dbg_addr = '0; dbg_din = '0;
    c3_req = 0; c3_rnw = 1; c3_addr = '0; c3_din = '0;
    d3_req = 0; d3_rnw = 1; d3_addr = '0; d3_din = '0;
    @(negedge clk);
    step();
    step();

    // Reset values
    chk1("rst_memRq", mem_rq, 1'b0);
    chk1("rst_rnw", rnw, 1'b1);
    chk16("rst_addr", addr, 16'h0000);
    chk16("rst_memDataWr", mem_wr, 16'h0000);
    chk1("rst_cpuAck", cpu_ack, 1'b0);
    chk1("rst_dbgAck", dbg_ack, 1'b0);
    chk16("rst_cpuDataOut", cpu_dout, 16'h0000);
    chk16("rst_dbgDataOut", dbg_dout, 16'h0000);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_grantDbg", grant_dbg, 1'b1);
    rst = 1'b0;
    step();

    // Debug preload mem[5] = 0x1234
    dbg_req = 1; dbg_rnw = 0; dbg_addr = 16'd5; dbg_din = 16'h1234;
    step();
    chk1("pre_memRq", mem_rq, 1'b1);
    chk1("pre_rnw", rnw, 1'b0);
    chk16("pre_addr", addr, 16'd5);
    chk16("pre_wdata", mem_wr, 16'h1234);
    chk1("pre_grantDbg", grant_dbg, 1'b1);
    chk1("pre_busy", busy, 1'b1);
    dbg_din = 16'hFFFF;  // operand change after grant must be ignored
    step();
    chk1("pre_dbgAck", dbg_ack, 1'b1);
    chk1("pre_done_memRq", mem_rq, 1'b0);
    chk1("pre_done_rnw", rnw, 1'b1);
    chk16("pre_done_wdata_held", mem_wr, 16'h1234);
    dbg_req = 0;
    step();
    chk16("pre_mem5", mem[5], 16'h1234);
    chk1("pre_idle_busy", busy, 1'b0);

    // CPU read addr 5: memRq cycle 1, ack cycle 2
    cpu_req = 1; cpu_rnw = 1; cpu_addr = 16'd5;
    step();
    chk1("crd_memRq", mem_rq, 1'b1);
    chk16("crd_addr", addr, 16'd5);
    chk1("crd_noack", cpu_ack, 1'b0);
    chk1("crd_grantDbg", grant_dbg, 1'b0);
    step();
    chk1("crd_cpuAck", cpu_ack, 1'b1);
    chk16("crd_data", cpu_dout, 16'h1234);
    chk1("crd_dbgAck", dbg_ack, 1'b0);
    chk1("crd_memRq_off", mem_rq, 1'b0);
    cpu_req = 0;
    step();
    chk1("crd_ack_once", cpu_ack, 1'b0);

    // Debug write addr 3 = 0xBEEF
    dbg_req = 1; dbg_rnw = 0; dbg_addr = 16'd3; dbg_din = 16'hBEEF;
    step();
    step();
    chk1("dwr_dbgAck", dbg_ack, 1'b1);
    chk16("dwr_dbgDataOut_kept", dbg_dout, 16'h0000);
    dbg_req = 0;
    step();
    chk16("dwr_mem3", mem[3], 16'hBEEF);

    // CPU read addr 3
    cpu_req = 1; cpu_rnw = 1; cpu_addr = 16'd3;
    step();
    step();
    chk1("crd3_ack", cpu_ack, 1'b1);
    chk16("crd3_data", cpu_dout, 16'hBEEF);
    cpu_req = 0;
    step();

    // CPU write leaves cpuDataOut unchanged
    cpu_req = 1; cpu_rnw = 0; cpu_addr = 16'd4; cpu_din = 16'h5555;
    step();
    chk1("cwr_rnw", rnw, 1'b0);
    step();
    chk1("cwr_ack", cpu_ack, 1'b1);
    chk16("cwr_dout_kept", cpu_dout, 16'hBEEF);
    cpu_req = 0;
    step();
    chk16("cwr_mem4", mem[4], 16'h5555);

    // CPU drops req mid-ACCESS: ack still pulses once
    cpu_req = 1; cpu_rnw = 1; cpu_addr = 16'd5;
    step();
    cpu_req = 0;
    step();
    chk1("drop_ack", cpu_ack, 1'b1);
    chk16("drop_data", cpu_dout, 16'h1234);
    step();
    chk1("drop_ack_once", cpu_ack, 1'b0);
    chk1("drop_busy", busy, 1'b0);
    step();
    chk1("drop_idle_busy", busy, 1'b0);
    chk1("drop_idle_memRq", mem_rq, 1'b0);

    // Reset, then both requesters continuously: CPU, DBG, CPU
    rst = 1;
    step();
    rst = 0;
    cpu_req = 1; cpu_rnw = 1; cpu_addr = 16'd5;
    dbg_req = 1; dbg_rnw = 1; dbg_addr = 16'd3;
    step();
    chk1("tie1_grantDbg", grant_dbg, 1'b0);
    chk16("tie1_addr", addr, 16'd5);
    step();
    chk1("tie1_cpuAck", cpu_ack, 1'b1);
    chk1("tie1_dbgAck", dbg_ack, 1'b0);
    chk16("tie1_data", cpu_dout, 16'h1234);
    step();
    step();
    chk1("tie2_grantDbg", grant_dbg, 1'b1);
    chk16("tie2_addr", addr, 16'd3);
    step();
    chk1("tie2_dbgAck", dbg_ack, 1'b1);
    chk1("tie2_cpuAck", cpu_ack, 1'b0);
    chk16("tie2_data", dbg_dout, 16'hBEEF);
    step();
    step();
    chk1("tie3_grantDbg", grant_dbg, 1'b0);
    chk1("tie3_memRq", mem_rq, 1'b1);
    step();
    chk1("tie3_cpuAck", cpu_ack, 1'b1);
    cpu_req = 0; dbg_req = 0;
    step();

    // Reset during ACCESS of a CPU write
    cpu_req = 1; cpu_rnw = 0; cpu_addr = 16'd9; cpu_din = 16'hAAAA;
    step();
    chk1("rac_memRq", mem_rq, 1'b1);
    rst = 1;
    step();
    rst = 0; cpu_req = 0;
    chk1("rac_memRq_off", mem_rq, 1'b0);
    chk1("rac_noack", cpu_ack, 1'b0);
    chk1("rac_rnw", rnw, 1'b1);
    chk16("rac_addr", addr, 16'h0000);
    chk16("rac_wdata", mem_wr, 16'h0000);
    chk16("rac_cpuDataOut", cpu_dout, 16'h0000);
    chk16("rac_dbgDataOut", dbg_dout, 16'h0000);
    chk1("rac_busy", busy, 1'b0);
    chk1("rac_grantDbg", grant_dbg, 1'b1);
    step();
    chk1("rac_noack_later", cpu_ack, 1'b0);

    // Debug read after the aborted access
    dbg_req = 1; dbg_rnw = 1; dbg_addr = 16'd5;
    step();
    step();
    chk1("rdbg_ack", dbg_ack, 1'b1);
    chk16("rdbg_data", dbg_dout, 16'h1234);
    dbg_req = 0;
    step();

    // WAIT_CYCLES = 3: preload mem3[7] via debug, then CPU read addr 7
    d3_req = 1; d3_rnw = 0; d3_addr = 16'd7; d3_din = 16'h7777;
    repeat (4) step();
    chk1("w3_pre_ack", d3_ack, 1'b1);
    d3_req = 0;
    step();
    c3_req = 1; c3_rnw = 1; c3_addr = 16'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1($sformatf("w3_memRq_c%0d", i + 1), mem_rq3, 1'b1);
      chk16($sformatf("w3_addr_c%0d", i + 1), addr3, 16'd7);
      chk1($sformatf("w3_noack_c%0d", i + 1), c3_ack, 1'b0);
    end
    step();
    chk1("w3_ack", c3_ack, 1'b1);
    chk16("w3_data", c3_dout, 16'h7777);
    chk1("w3_memRq_off", mem_rq3, 1'b0);
    c3_req = 0;
    step();
    chk1("w3_ack_once", c3_ack, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
